tmr_voter: RTL

Downstream consumer of the three error-injection lanes. It receives three copies of the 2*cmd_l-bit command word and produces one registered command. The block normally runs in SIMPLEX mode, where it passes lane A through and uses lane B as a duplex check. On any disagreement it escalates to TMR mode, where it outputs a bitwise 2-of-3 majority vote. It returns to SIMPLEX after a clean hold window. It also reports the faulty lane, an error count, and an unrecoverable-disagreement flag.

---
 rtl/tmr_voter.sv | 72 +++++++
 1 files changed

// File: rtl/tmr_voter.sv
// tmr_voter: duplex-checked simplex pass-through that escalates to 2-of-3 TMR voting on disagreement
module tmr_voter #(
  parameter int cmd_l = 4,
  parameter int hold_cyc = 16,
  parameter int cnt_w = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*cmd_l-1:0] cmd_a,
  input  logic [2*cmd_l-1:0] cmd_b,
  input  logic [2*cmd_l-1:0] cmd_c,
  output logic               out_valid,
  output logic [2*cmd_l-1:0] cmd_out,
  output logic               mode,
  output logic [1:0]         err_lane,
  output logic               fault,
  output logic [cnt_w-1:0]   err_cnt
);
  localparam int hw = $clog2(hold_cyc) + 1;
  typedef enum logic {simplex = 1'b0, tmr = 1'b1} mode_t;
  mode_t state, state_nxt;
  logic [hw-1:0] hold_cnt, hold_nxt;
  logic [2*cmd_l-1:0] maj;
  logic eab, ebc, eac, all_diff, bad;
  logic [1:0] lane_nxt;
  assign maj = (cmd_a & cmd_b) | (cmd_b & cmd_c) | (cmd_a & cmd_c);
  assign eab = cmd_a != cmd_b;
  assign ebc = cmd_b != cmd_c;
  assign eac = cmd_a != cmd_c;
  assign all_diff = eab & ebc & eac;
  // simplex only checks A against B, so C alone can never raise an error there
  assign bad = (state == simplex) ? eab : (eab | ebc);
  assign lane_nxt = (eab && eac && !ebc) ? 2'd1 :
                    (eab && ebc && !eac) ? 2'd2 :
                    (ebc && eac && !eab) ? 2'd3 : 2'd0;
  assign mode = state;
  // mode transitions and clean-sample hold window
  always_comb begin
    state_nxt = state;
    hold_nxt = hold_cnt;
    if (in_valid && bad) begin
      state_nxt = tmr;
      hold_nxt = '0;
    end else if (in_valid && state == tmr) begin
      state_nxt = (hold_cnt == hw'(hold_cyc - 1)) ? simplex : tmr;
      hold_nxt = (hold_cnt == hw'(hold_cyc - 1)) ? '0 : hold_cnt + 1'b1;
    end
  end
  // state, hold counter and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= simplex;
      hold_cnt <= '0;
      out_valid <= 1'b0;
      cmd_out <= '0;
      err_lane <= 2'd0;
      fault <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      hold_cnt <= hold_nxt;
      out_valid <= in_valid;
      fault <= in_valid & bad & all_diff;
      if (in_valid) cmd_out <= (state == simplex && !eab) ? cmd_a : maj;
      if (in_valid && bad) begin
        err_lane <= lane_nxt;
        err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
      end
    end
  end
endmodule
